// File: rtl/mem_cache_pkg.sv
// Shared types and address-field helpers for the set-associative write-back cache.
package mem_cache_pkg;

  localparam int WORD_W = 64;

  typedef enum logic [1:0] {IDLE, LOOKUP, WB, FILL} state_t;

  // Sub-steps of one backing-memory transaction: wait for idle, pulse strobe, wait for done.
  typedef enum logic [1:0] {PH_ISSUE, PH_STROBE, PH_WAIT} phase_t;

  function automatic logic [WORD_W-1:0] addr_offset(input logic [WORD_W-1:0] a, input int lsb);
    return a & ((64'd1 << lsb) - 64'd1);
  endfunction

  function automatic logic [WORD_W-1:0] addr_index(input logic [WORD_W-1:0] a, input int lsb,
                                                   input int lcb);
    return (a >> lsb) & ((64'd1 << lcb) - 64'd1);
  endfunction

  function automatic logic [WORD_W-1:0] addr_tag(input logic [WORD_W-1:0] a, input int lsb,
                                                 input int lcb);
    return a >> (lsb + lcb);
  endfunction

endpackage

// File: rtl/mem_cache_way_select.sv
// Combinational hit detection across the ways of one set, plus victim choice
// (lowest invalid way first, otherwise the set's round-robin pointer).
module cache_way_select #(
  parameter int ASSOC_BITS = 2,
  parameter int TAG_W      = 54
) (
  input  logic [(1<<ASSOC_BITS)-1:0]            i_valid,
  input  logic [(1<<ASSOC_BITS)-1:0][TAG_W-1:0] i_tags,
  input  logic [TAG_W-1:0]                      i_tag,
  input  logic [ASSOC_BITS-1:0]                 i_rr,
  output logic                                  o_hit,
  output logic [ASSOC_BITS-1:0]                 o_hit_way,
  output logic [ASSOC_BITS-1:0]                 o_victim_way
);

  localparam int WAYS = 1 << ASSOC_BITS;

  logic                  w_has_invalid;
  logic [ASSOC_BITS-1:0] w_first_invalid;

  // Descending scan so the lowest-numbered match/invalid way is the one kept.
  always_comb begin
    o_hit           = 1'b0;
    o_hit_way       = '0;
    w_has_invalid   = 1'b0;
    w_first_invalid = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (i_valid[w] && (i_tags[w] == i_tag)) begin
        o_hit     = 1'b1;
        o_hit_way = ASSOC_BITS'(w);
      end
      if (!i_valid[w]) begin
        w_has_invalid   = 1'b1;
        w_first_invalid = ASSOC_BITS'(w);
      end
    end
    o_victim_way = w_has_invalid ? w_first_invalid : i_rr;
  end

endmodule

// File: rtl/mem_cache.sv
// Set-associative write-back, write-allocate cache between a requester and a
// slower backing memory; both sides use a re/we/ready handshake.
module mem_cache
  import mem_cache_pkg::*;
#(
  parameter int LINE_SIZE_BITS  = 2,
  parameter int LINE_COUNT_BITS = 8,
  parameter int ASSOC_BITS      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout,
  input  logic              re,
  input  logic              we,
  output logic              ready,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_dout,
  input  logic [WORD_W-1:0] mem_din,
  output logic              mem_re,
  output logic              mem_we,
  input  logic              mem_ready,
  output state_t            o_dbg_state
);

  // Requester handshake: a request is taken on a rising edge where ready=1 and
  // re or we is high (we wins); ready stays low until the access has completed.
  localparam int WAYS  = 1 << ASSOC_BITS;
  localparam int SETS  = 1 << LINE_COUNT_BITS;
  localparam int WORDS = 1 << LINE_SIZE_BITS;
  localparam int TAG_W = WORD_W - LINE_SIZE_BITS - LINE_COUNT_BITS;

  logic [WORD_W-1:0]     r_data  [SETS][WAYS][WORDS];
  logic [TAG_W-1:0]      r_tag   [SETS][WAYS];
  logic [WAYS-1:0]       r_valid [SETS];
  logic [WAYS-1:0]       r_dirty [SETS];
  logic [ASSOC_BITS-1:0] r_rr    [SETS];

  state_t                r_state;
  phase_t                r_phase;
  logic [WORD_W-1:0]     r_addr, r_din, r_dout, r_mem_addr, r_mem_dout;
  logic                  r_we, r_ready, r_mem_re, r_mem_we;
  logic [LINE_SIZE_BITS-1:0] r_word;
  logic [ASSOC_BITS-1:0] r_way;

  logic [LINE_SIZE_BITS-1:0]  w_offset;
  logic [LINE_COUNT_BITS-1:0] w_index;
  logic [TAG_W-1:0]           w_tag;
  logic [WAYS-1:0][TAG_W-1:0] w_set_tags;
  logic                       w_hit, w_last_word;
  logic [ASSOC_BITS-1:0]      w_hit_way, w_victim_way;
  logic [WORD_W-1:0]          w_wb_addr, w_fill_addr;

  assign w_offset    = LINE_SIZE_BITS'(addr_offset(r_addr, LINE_SIZE_BITS));
  assign w_index     = LINE_COUNT_BITS'(addr_index(r_addr, LINE_SIZE_BITS, LINE_COUNT_BITS));
  assign w_tag       = TAG_W'(addr_tag(r_addr, LINE_SIZE_BITS, LINE_COUNT_BITS));
  assign w_last_word = &r_word;
  assign w_wb_addr   = {r_tag[w_index][r_way], w_index, r_word};
  assign w_fill_addr = {w_tag, w_index, r_word};

  always_comb begin
    w_set_tags = '0;
    for (int w = 0; w < WAYS; w++) w_set_tags[w] = r_tag[w_index][w];
  end

  cache_way_select #(.ASSOC_BITS(ASSOC_BITS), .TAG_W(TAG_W)) u_way_select (
    .i_valid      (r_valid[w_index]),
    .i_tags       (w_set_tags),
    .i_tag        (w_tag),
    .i_rr         (r_rr[w_index]),
    .o_hit        (w_hit),
    .o_hit_way    (w_hit_way),
    .o_victim_way (w_victim_way)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_phase    <= PH_ISSUE;
      r_ready    <= 1'b1;
      r_dout     <= '0;
      r_mem_re   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_dout <= '0;
      r_addr     <= '0;
      r_din      <= '0;
      r_we       <= 1'b0;
      r_word     <= '0;
      r_way      <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        r_rr[s]    <= '0;
      end
    end else begin
      case (r_state)
        IDLE: if (re || we) begin
          r_addr  <= addr;
          r_din   <= din;
          r_we    <= we;
          r_ready <= 1'b0;
          r_state <= LOOKUP;
        end
        LOOKUP: if (w_hit) begin
          if (r_we) begin
            r_data[w_index][w_hit_way][w_offset] <= r_din;
            r_dirty[w_index][w_hit_way]          <= 1'b1;
          end else begin
            r_dout <= r_data[w_index][w_hit_way][w_offset];
          end
          r_ready <= 1'b1;
          r_state <= IDLE;
        end else begin
          r_way   <= w_victim_way;
          r_word  <= '0;
          r_phase <= PH_ISSUE;
          if (&r_valid[w_index]) r_rr[w_index] <= r_rr[w_index] + ASSOC_BITS'(1);
          r_state <= (r_valid[w_index][w_victim_way] && r_dirty[w_index][w_victim_way]) ? WB : FILL;
        end
        WB: case (r_phase)
          PH_ISSUE: if (mem_ready) begin
            r_mem_we   <= 1'b1;
            r_mem_addr <= w_wb_addr;
            r_mem_dout <= r_data[w_index][r_way][r_word];
            r_phase    <= PH_STROBE;
          end
          PH_STROBE: begin
            r_mem_we <= 1'b0;
            r_phase  <= PH_WAIT;
          end
          default: if (mem_ready) begin
            r_phase <= PH_ISSUE;
            r_word  <= r_word + LINE_SIZE_BITS'(1);
            if (w_last_word) r_state <= FILL;
          end
        endcase
        FILL: case (r_phase)
          PH_ISSUE: if (mem_ready) begin
            r_mem_re   <= 1'b1;
            r_mem_addr <= w_fill_addr;
            r_phase    <= PH_STROBE;
          end
          PH_STROBE: begin
            r_mem_re <= 1'b0;
            r_phase  <= PH_WAIT;
          end
          default: if (mem_ready) begin
            r_data[w_index][r_way][r_word] <= mem_din;
            r_phase <= PH_ISSUE;
            r_word  <= r_word + LINE_SIZE_BITS'(1);
            if (w_last_word) begin
              r_valid[w_index][r_way] <= 1'b1;
              r_dirty[w_index][r_way] <= r_we;
              r_tag[w_index][r_way]   <= w_tag;
              // The word arriving this edge is not in the array yet, so bypass it.
              if (r_we) r_data[w_index][r_way][w_offset] <= r_din;
              else r_dout <= (w_offset == r_word) ? mem_din : r_data[w_index][r_way][w_offset];
              r_ready <= 1'b1;
              r_state <= IDLE;
            end
          end
        endcase
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dout        = r_dout;
  assign ready       = r_ready;
  assign mem_addr    = r_mem_addr;
  assign mem_dout    = r_mem_dout;
  assign mem_re      = r_mem_re;
  assign mem_we      = r_mem_we;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_cache.sv
// Directed bench for mem_cache: flat-memory reference model with an in-order
// expectation queue, a latency-bearing backing RAM, and literal spot checks.
module tb_mem_cache;
  import mem_cache_pkg::*;

  localparam int LSB = 1;
  localparam int LCB = 3;
  localparam int AB  = 3;
  localparam int LAT = 2;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] XV   = 64'h0123_4567_89ab_cdef;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] addr = '0, din = '0, dout;
  logic        re = 1'b0, we = 1'b0, ready;
  logic [63:0] mem_addr, mem_dout, mem_din;
  logic        mem_re, mem_we, mem_ready;
  state_t      dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_cache #(.LINE_SIZE_BITS(LSB), .LINE_COUNT_BITS(LCB), .ASSOC_BITS(AB)) dut (
    .clk(clk), .rst(rst), .addr(addr), .din(din), .dout(dout), .re(re), .we(we),
    .ready(ready), .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din),
    .mem_re(mem_re), .mem_we(mem_we), .mem_ready(mem_ready), .o_dbg_state(dbg_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Backing RAM: busy for LAT cycles after each strobe; unwritten words read all-ones.
  logic [63:0] ram_mem [0:1023];
  bit          ram_wv  [0:1023];
  logic [63:0] ram_q = '0;
  int          ram_cnt = 0;
  int          ram_rd = 0;
  int          ram_wr = 0;

  assign mem_ready = (ram_cnt == 0);
  assign mem_din   = ram_q;

  always @(posedge clk) begin
    if (ram_cnt != 0) ram_cnt <= ram_cnt - 1;
    else if (mem_we) begin
      ram_mem[mem_addr[9:0]] <= mem_dout;
      ram_wv[mem_addr[9:0]]  <= 1'b1;
      ram_cnt <= LAT;
      ram_wr  <= ram_wr + 1;
    end else if (mem_re) begin
      ram_q   <= ram_wv[mem_addr[9:0]] ? ram_mem[mem_addr[9:0]] : ONES;
      ram_cnt <= LAT;
      ram_rd  <= ram_rd + 1;
    end
  end

  // Reference model: what the requester must observe of a flat word memory.
  typedef struct {
    bit          is_wr;
    logic [63:0] a;
    logic [63:0] d;
  } req_t;

  req_t        exp_q[$];
  logic [63:0] exp_mem [logic [63:0]];
  logic [63:0] model_dout = '0;
  bit          prev_strobe = 1'b0;

  always @(negedge clk) begin
    req_t r;
    if (rst) begin
      exp_q.delete();
      model_dout  = '0;
      prev_strobe = 1'b0;
    end else begin
      if (mem_re && mem_we) check("strobe_excl", 64'(mem_re & mem_we), 64'd0);
      if (mem_re || mem_we) begin
        check("strobe_when_idle", 64'(mem_ready), 64'd1);
        check("strobe_one_cycle", 64'(prev_strobe), 64'd0);
      end
      if (ready && exp_q.size() > 0) begin
        r = exp_q.pop_front();
        if (r.is_wr) exp_mem[r.a] = r.d;
        else model_dout = exp_mem.exists(r.a) ? exp_mem[r.a] : ONES;
        check("dout_complete", dout, model_dout);
      end else if (ready) begin
        check("dout_hold", dout, model_dout);
      end
      if (ready && (re || we)) exp_q.push_back('{we, addr, din});
      prev_strobe = mem_re | mem_we;
    end
  end

  // Driver: called just after a rising edge with ready=1; returns busy cycles and RAM traffic.
  task automatic access(input bit w, input logic [63:0] a, input logic [63:0] d,
                        output int cycles, output int nrd, output int nwr);
    int rd0, wr0;
    rd0 = ram_rd;
    wr0 = ram_wr;
    we = w; re = !w; addr = a; din = d;
    @(posedge clk); #1;
    we = 1'b0; re = 1'b0;
    cycles = 0;
    while (!ready && cycles < 500) begin
      @(posedge clk); #1;
      cycles++;
    end
    if (!ready) check("ready_timeout", 64'(ready), 64'd1);
    nrd = ram_rd - rd0;
    nwr = ram_wr - wr0;
  endtask

  task automatic wr(input logic [63:0] a, input logic [63:0] d);
    int c, nr, nw;
    access(1'b1, a, d, c, nr, nw);
  endtask

  task automatic rd(input string nm, input logic [63:0] a, input logic [63:0] e);
    int c, nr, nw;
    access(1'b0, a, '0, c, nr, nw);
    check(nm, dout, e);
  endtask

  initial begin
    int c, nr, nw;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_dout", dout, 64'd0);
    check("rst_mem_re", 64'(mem_re), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_mem_dout", mem_dout, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_ready", 64'(ready), 64'd1);
    check("idle_strobes", 64'(mem_re | mem_we), 64'd0);

    // Abandon a miss mid-fill: the write must not survive.
    we = 1'b1; addr = 64'd500; din = 64'hAA;
    @(posedge clk); #1;
    we = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midop_busy", 64'(ready), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_ready", 64'(ready), 64'd1);
    check("midrst_strobes", 64'(mem_re | mem_we), 64'd0);
    check("midrst_state", 64'(dbg_state), 64'(IDLE));
    @(posedge clk); #1;
    rd("midrst_read500", 64'd500, ONES);

    access(1'b1, 64'd1, XV, c, nr, nw);
    check("miss_busy", 64'(c > 1), 64'd1);
    check("clean_miss_rd", 64'(nr), 64'd2);
    check("clean_miss_wr", 64'(nw), 64'd0);
    access(1'b0, 64'd1, '0, c, nr, nw);
    check("hit_latency", 64'(c), 64'd1);
    check("hit_no_traffic", 64'(nr + nw), 64'd0);
    check("read1", dout, XV);
    rd("read0_ones", 64'd0, ONES);

    wr(64'd257, 64'd123);
    wr(64'd256, 64'd321);
    rd("reread1", 64'd1, XV);
    rd("reread256", 64'd256, 64'd321);
    rd("reread257", 64'd257, 64'd123);
    wr(64'd1, 64'd5);
    rd("over1", 64'd1, 64'd5);
    rd("keep257", 64'd257, 64'd123);
    rd("keep256", 64'd256, 64'd321);

    // Fill set 0 (lines 0,128 already resident), then force round-robin dirty evictions.
    for (int k = 1; k <= 6; k++) wr(64'(16 * k), 64'(1000 + k));
    access(1'b1, 64'd112, 64'd7, c, nr, nw);
    check("evict0_wr", 64'(nw), 64'd2);
    check("evict0_rd", 64'(nr), 64'd2);
    access(1'b0, 64'd1, '0, c, nr, nw);
    check("evict1_wr", 64'(nw), 64'd2);
    check("refill1", dout, 64'd5);
    access(1'b0, 64'd257, '0, c, nr, nw);
    check("evict2_wr", 64'(nw), 64'd2);
    check("refill257", dout, 64'd123);
    rd("evicted16", 64'd16, 64'd1001);

    for (int j = 2; j <= 99; j++) begin
      for (int i = 0; i < j; i++) wr(64'(i), 64'(i));
      for (int i = 0; i < j; i++) rd("sweep", 64'(i), 64'(i));
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #(950_000);
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_cache.md
# mem_cache

Parameterised set-associative, write-back, write-allocate cache for 64-bit word-addressed memory. It sits between a requester, such as a CPU model or scratchpad, and a slower backing memory such as the `ram` block. Both sides use the same re/we/ready handshake. The cache hides backing-memory latency on hits and transfers whole lines on misses.

## Interface
- LINE_SIZE_BITS, 2: log2 of words per line.
- LINE_COUNT_BITS, 8: log2 of the number of sets.
- ASSOC_BITS, 2: log2 of ways per set.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; one clock, synchronous, active-high.
- addr  in  64  requester word address.
- din  in  64  requester write data.
- dout  out  64  read data.
- re  in  1  read request.
- we  in  1  write request.
- ready  out  1  idle and able to accept a request.
- mem_addr  out  64  backing word address.
- mem_dout  out  64  write data to backing memory.
- mem_din  in  64  read data from backing memory.
- mem_re  out  1  backing read strobe.
- mem_we  out  1  backing write strobe.
- mem_ready  in  1  backing memory idle; after a read, mem_din is valid.

## Operation
- Address split:
  - offset = addr[LINE_SIZE_BITS-1:0].
  - index = next LINE_COUNT_BITS bits.
  - tag = remaining upper bits.
- Per way and set: valid bit, dirty bit, tag, and line data of 2^LINE_SIZE_BITS words.
- Request acceptance: a request is accepted only on an edge where ready=1 and re or we is high. If both are high, we wins. Requests while ready=0 are ignored.
- Hit: any valid way in the set whose tag matches.
  - Read hit: dout ← word.
  - Write hit: word ← din; dirty ← 1.
- Miss, victim selection: first invalid way (lowest index). If none, use the per-set round-robin pointer, then advance that pointer.
- Miss, write-back: if the victim is dirty, write each of its words to backing memory, ascending offset.
- Miss, fill: read all words of the new line from backing memory, ascending offset. Set valid=1, dirty=0, new tag.
- Miss, completion: finish the original access exactly as for a hit.
- Backing transaction: wait until mem_ready=1. Drive mem_re or mem_we high for exactly one cycle with mem_addr (and mem_dout for writes). Then wait for mem_ready=1; on reads, capture mem_din at that point.
- dout holds the last read result until the next read completes. Writes do not change dout.
- Backing memory contract for the bench `ram`: word-addressed; never-written words read as all-ones (0xFFFF_FFFF_FFFF_FFFF).
- State machine:
  - IDLE → LOOKUP on an accepted request.
  - LOOKUP → IDLE on a hit, with the access completed.
  - LOOKUP → WB if the victim is dirty, else → FILL.
  - WB → FILL after the last word is written.
  - FILL → IDLE after the last word is read, with the access completed.

## Timing
- Reset values: ready=1, dout=0, mem_re=0, mem_we=0, mem_addr=0, mem_dout=0; all valid, dirty and pointer state cleared; state IDLE.
- Reset mid-operation: abandon the transfer, invalidate all lines (dirty data discarded), and return to IDLE with ready=1 on the next edge.
- Hit latency: request accepted at edge N; ready=0 after N; at edge N+1, ready=1 and dout valid for reads.
- Miss latency: 1 + (dirty ? W : 0) + W backing transactions, where W = 2^LINE_SIZE_BITS. Each backing transaction adds at least one cycle beyond the backing memory's own latency.
- ready is 0 from the edge after acceptance until completion. It is registered, with no combinational path from re/we.
- Backing strobes last one cycle; mem_re and mem_we are never high together.

## Structure
- Shared package:
  - word width (64);
  - state enum (IDLE, LOOKUP, WB, FILL);
  - address-field helper functions (offset, index, tag) parameterised by LINE_SIZE_BITS and LINE_COUNT_BITS.
- Storage arrays and the controller live in one module.
- One sub-module is natural: `cache_way_select`, combinational. It performs hit detection across ways and victim choice (invalid-first, else round-robin).

## Test plan
- Reset, then idle one cycle → ready=1, no backing strobes.
- Write [1] ← 0x0123456789abcdef → ready=0 on the next cycle (miss fill); then read [1] → ready=0 for one cycle, then ready=1 with dout=0x0123456789abcdef.
- Read [0] → dout=0xFFFFFFFFFFFFFFFF (all-ones from backing memory).
- With LINE_SIZE_BITS=1, LINE_COUNT_BITS=3, ASSOC_BITS=3:
  - write [257] ← 123 and [256] ← 321;
  - re-read [1], [256], [257] → 0x0123456789abcdef, 321, 123 respectively.
- Overwrite [1] ← 5 → read [1]=5; [257]=123 and [256]=321 unchanged.
- For j=2..99: write [i] ← i for i<j, then read each back → dout=i. This exercises eviction of dirty lines with write-back and refill.
